cb_sweep_sched: RTL and testbench

Scheduler in front of the covariance-block address generator. It arbitrates between two requesters: the prediction unit (requester 0) and the update unit (requester 1). Each requester asks for a rectangular sweep of covariance-block elements. The block serialises each granted sweep into one (row, col) pair per cycle on the generator's `CB_row`/`CB_col` inputs. It also runs a tag/valid/last pipeline matched to the generator latency, so each returned `CB_base_addr` is qualified and attributed to its requester.

---
 rtl/cb_sweep_sched.sv | 129 ++++++++++++
 tb/tb_cb_sweep_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_sweep_sched.sv
// rtl/cb_sweep_sched.sv - two-requester sweep scheduler for the covariance-block address generator
// Serialises rectangular sweeps into one (row, col) per cycle and tags returned addresses.
module cb_sweep_sched #(
  parameter int ROW_LEN = 10,
  parameter int LEN_W   = 4,
  parameter int AGD_LAT = 5
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               req0_valid,
  input  logic [ROW_LEN-1:0] req0_row,
  input  logic [ROW_LEN-1:0] req0_col,
  input  logic [LEN_W-1:0]   req0_nrow,
  input  logic [LEN_W-1:0]   req0_ncol,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [ROW_LEN-1:0] req1_row,
  input  logic [ROW_LEN-1:0] req1_col,
  input  logic [LEN_W-1:0]   req1_nrow,
  input  logic [LEN_W-1:0]   req1_ncol,
  output logic               req1_ready,
  input  logic               hold,
  output logic [ROW_LEN-1:0] agd_row,
  output logic [ROW_LEN-1:0] agd_col,
  output logic               agd_issue,
  output logic               addr_valid,
  output logic               addr_tag,
  output logic               addr_last,
  output logic [1:0]         done,
  output logic               busy
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t             state;
  logic               last_grant;
  logic               owner;
  logic [ROW_LEN-1:0] base_row, base_col;
  logic [LEN_W-1:0]   nrow_q, ncol_q, r_cnt, c_cnt, r_nxt, c_nxt;
  logic               grant0, grant1, accept, col_end, is_last;
  logic [ROW_LEN-1:0] sel_row, sel_col;
  logic [LEN_W-1:0]   sel_nrow, sel_ncol;
  logic [AGD_LAT-1:0] pv, pt, pl;

  // last_grant==1 means requester 0 has priority on a tie
  always_comb begin
    grant0   = req0_valid && (!req1_valid || last_grant);
    grant1   = req1_valid && (!req0_valid || !last_grant);
    sel_row  = grant1 ? req1_row  : req0_row;
    sel_col  = grant1 ? req1_col  : req0_col;
    sel_nrow = grant1 ? req1_nrow : req0_nrow;
    sel_ncol = grant1 ? req1_ncol : req0_ncol;
    if (sel_nrow == '0) sel_nrow = ONE;
    if (sel_ncol == '0) sel_ncol = ONE;
  end

  assign req0_ready = (state == IDLE) && grant0 && !sys_rst;
  assign req1_ready = (state == IDLE) && grant1 && !sys_rst;
  assign accept     = req0_ready || req1_ready;
  assign agd_issue  = (state == SWEEP) && !hold;

  assign col_end = (c_cnt == ncol_q - ONE);
  assign is_last = col_end && (r_cnt == nrow_q - ONE);
  assign c_nxt   = col_end ? '0 : c_cnt + ONE;
  assign r_nxt   = col_end ? r_cnt + ONE : r_cnt;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      base_row   <= '0;
      base_col   <= '0;
      nrow_q     <= ONE;
      ncol_q     <= ONE;
      r_cnt      <= '0;
      c_cnt      <= '0;
      agd_row    <= '0;
      agd_col    <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        owner      <= req1_ready;
        last_grant <= req1_ready;
        base_row   <= sel_row;
        base_col   <= sel_col;
        nrow_q     <= sel_nrow;
        ncol_q     <= sel_ncol;
        r_cnt      <= '0;
        c_cnt      <= '0;
        agd_row    <= sel_row;
        agd_col    <= sel_col;
        state      <= SWEEP;
      end
    end else if (!hold) begin
      // the final pair stays on agd_row/agd_col until the next accept
      if (is_last) begin
        state <= IDLE;
      end else begin
        c_cnt   <= c_nxt;
        r_cnt   <= r_nxt;
        agd_row <= base_row + ROW_LEN'(r_nxt);
        agd_col <= base_col + ROW_LEN'(c_nxt);
      end
    end
  end

  // return pipeline shifts every cycle, bubbles included
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pv <= '0;
      pt <= '0;
      pl <= '0;
    end else begin
      pv <= {pv[AGD_LAT-2:0], agd_issue};
      pt <= {pt[AGD_LAT-2:0], owner};
      pl <= {pl[AGD_LAT-2:0], agd_issue && is_last};
    end
  end

  assign addr_valid = pv[AGD_LAT-1];
  assign addr_tag   = pt[AGD_LAT-1];
  assign addr_last  = pl[AGD_LAT-1];
  assign done       = {addr_valid && addr_last && addr_tag,
                       addr_valid && addr_last && !addr_tag};
  assign busy       = (state == SWEEP) || (|pv);

endmodule

// File: tb/tb_cb_sweep_sched.sv
// tb/tb_cb_sweep_sched.sv - directed self-checking bench for cb_sweep_sched
module tb_cb_sweep_sched;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, hold = 1'b0;
  logic [9:0] req0_row = '0, req0_col = '0, req1_row = '0, req1_col = '0;
  logic [3:0] req0_nrow = '0, req0_ncol = '0, req1_nrow = '0, req1_ncol = '0;
  logic       req0_ready, req1_ready, agd_issue, addr_valid, addr_tag, addr_last, busy;
  logic [9:0] agd_row, agd_col;
  logic [1:0] done;

  cb_sweep_sched #(.ROW_LEN(10), .LEN_W(4), .AGD_LAT(5)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .req0_valid(req0_valid), .req0_row(req0_row), .req0_col(req0_col),
    .req0_nrow(req0_nrow), .req0_ncol(req0_ncol), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_row(req1_row), .req1_col(req1_col),
    .req1_nrow(req1_nrow), .req1_ncol(req1_ncol), .req1_ready(req1_ready),
    .hold(hold), .agd_row(agd_row), .agd_col(agd_col), .agd_issue(agd_issue),
    .addr_valid(addr_valid), .addr_tag(addr_tag), .addr_last(addr_last),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int a; int b;} ev_t;
  ev_t iss_q[$], val_q[$], done_q[$], bsy_q[$];
  int  cyc = 0;
  int  n_chk = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (agd_issue) iss_q.push_back('{cyc, int'(agd_row), int'(agd_col)});
    if (addr_valid) val_q.push_back('{cyc, int'(addr_tag), int'(addr_last)});
    if (done != 2'b00) done_q.push_back('{cyc, int'(done), 0});
    bsy_q.push_back('{cyc, int'(busy), 0});
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    iss_q.delete(); val_q.delete(); done_q.delete(); bsy_q.delete();
  endtask

  task automatic send(input int n, input int row, input int col, input int nr, input int nc,
                      output int acc);
    int k = 0;
    if (n == 0) begin
      req0_row = 10'(row); req0_col = 10'(col); req0_nrow = 4'(nr); req0_ncol = 4'(nc);
      req0_valid = 1'b1;
    end else begin
      req1_row = 10'(row); req1_col = 10'(col); req1_nrow = 4'(nr); req1_ncol = 4'(nc);
      req1_valid = 1'b1;
    end
    @(negedge clk);
    while (!((n == 0) ? req0_ready : req1_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("send_timeout", k, 0);
    acc = cyc;
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk("idle_timeout", k, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_row"}, int'(agd_row), 0);
    chk({tag, "_col"}, int'(agd_col), 0);
    chk({tag, "_issue"}, int'(agd_issue), 0);
    chk({tag, "_avalid"}, int'(addr_valid), 0);
    chk({tag, "_atag"}, int'(addr_tag), 0);
    chk({tag, "_alast"}, int'(addr_last), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rdy0"}, int'(req0_ready), 0);
  endtask

  int a0, a1, nb;
  int exp_r[6] = '{8, 8, 8, 9, 9, 9};
  int exp_c[6] = '{10, 11, 12, 10, 11, 12};

  initial begin
    // reset: ready gated even with a valid request present
    req0_valid = 1'b1; req0_row = 10'd1; req0_col = 10'd1; req0_nrow = 4'd1; req0_ncol = 4'd1;
    @(negedge clk);
    chk("rst_rdy_gated", int'(req0_ready), 0);
    repeat (2) @(posedge clk);
    #1 sys_rst = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    chk("rst_rdy1", int'(req1_ready), 0);
    @(posedge clk); #1;

    // single sweep 2x3 at (8,10)
    clear_logs();
    send(0, 8, 10, 2, 3, a0);
    wait_idle();
    chk("s1_n_iss", iss_q.size(), 6);
    chk("s1_n_val", val_q.size(), 6);
    for (int i = 0; i < 6 && i < iss_q.size() && i < val_q.size(); i++) begin
      chk("s1_iss_cyc", iss_q[i].cyc, a0 + 1 + i);
      chk("s1_row", iss_q[i].a, exp_r[i]);
      chk("s1_col", iss_q[i].b, exp_c[i]);
      chk("s1_val_cyc", val_q[i].cyc, a0 + 6 + i);
      chk("s1_tag", val_q[i].a, 0);
      chk("s1_last", val_q[i].b, (i == 5) ? 1 : 0);
    end
    chk("s1_n_done", done_q.size(), 1);
    if (done_q.size() > 0) begin
      chk("s1_done_cyc", done_q[0].cyc, a0 + 11);
      chk("s1_done_val", done_q[0].a, 1);
    end

    // simultaneous requests after reset: req0 first, req1 two cycles after its last issue
    sys_rst = 1'b1; repeat (2) @(posedge clk); #1 sys_rst = 1'b0;
    clear_logs();
    fork
      send(0, 5, 6, 1, 2, a0);
      send(1, 20, 30, 1, 2, a1);
    join
    wait_idle();
    chk("p1_acc_gap", a1 - a0, 3);
    chk("p1_n_iss", iss_q.size(), 4);
    if (iss_q.size() == 4) begin
      chk("p1_iss0", iss_q[0].cyc, a0 + 1);
      chk("p1_col1", iss_q[1].b, 7);
      chk("p1_iss2", iss_q[2].cyc, a0 + 4);
      chk("p1_row2", iss_q[2].a, 20);
      chk("p1_col3", iss_q[3].b, 31);
    end
    chk("p1_n_val", val_q.size(), 4);
    if (val_q.size() == 4) begin
      chk("p1_tags", val_q[0].a * 8 + val_q[1].a * 4 + val_q[2].a * 2 + val_q[3].a, 3);
      chk("p1_lasts", val_q[0].b * 8 + val_q[1].b * 4 + val_q[2].b * 2 + val_q[3].b, 5);
    end
    chk("p1_n_done", done_q.size(), 2);
    if (done_q.size() == 2) begin
      chk("p1_done0", done_q[0].a, 1);
      chk("p1_done0_cyc", done_q[0].cyc, a0 + 7);
      chk("p1_done1", done_q[1].a, 2);
      chk("p1_done1_cyc", done_q[1].cyc, a0 + 10);
    end

    // one more req0 grant, then a tie goes to req1
    send(0, 0, 0, 1, 1, a0);
    wait_idle();
    clear_logs();
    fork
      send(0, 11, 12, 1, 1, a0);
      send(1, 13, 14, 1, 1, a1);
    join
    wait_idle();
    chk("rr_req1_first", a0 - a1, 2);
    if (iss_q.size() > 0) chk("rr_first_row", iss_q[0].a, 13);

    // hold for 3 cycles after the 2nd issue of a 1x4 req1 sweep
    clear_logs();
    send(1, 40, 50, 1, 4, a1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_issue", int'(agd_issue), 0);
      chk("hold_col", int'(agd_col), 52);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    wait_idle();
    chk("hold_n_iss", iss_q.size(), 4);
    if (iss_q.size() == 4) begin
      chk("hold_iss2_cyc", iss_q[2].cyc, a1 + 6);
      chk("hold_iss3_col", iss_q[3].b, 53);
    end
    chk("hold_n_val", val_q.size(), 4);
    if (val_q.size() == 4) begin
      chk("hold_val1_cyc", val_q[1].cyc, a1 + 7);
      chk("hold_val2_cyc", val_q[2].cyc, a1 + 11);
    end
    chk("hold_n_done", done_q.size(), 1);
    if (done_q.size() == 1) chk("hold_done", done_q[0].a, 2);

    // zero row count clamps to 1; index wrap
    clear_logs();
    send(0, 1023, 1022, 0, 2, a0);
    wait_idle();
    chk("z_n_iss", iss_q.size(), 2);
    if (iss_q.size() == 2) begin
      chk("z_row0", iss_q[0].a, 1023);
      chk("z_col0", iss_q[0].b, 1022);
      chk("z_col1", iss_q[1].b, 1023);
    end
    chk("z_n_done", done_q.size(), 1);
    clear_logs();
    send(0, 1023, 1023, 2, 1, a0);
    wait_idle();
    chk("w_n_iss", iss_q.size(), 2);
    if (iss_q.size() == 2) begin
      chk("w_row0", iss_q[0].a, 1023);
      chk("w_row1", iss_q[1].a, 0);
      chk("w_col1", iss_q[1].b, 1023);
    end
    if (val_q.size() == 2) chk("w_last", val_q[1].b, 1);

    // reset during the 3rd issue of a 4x4 sweep
    clear_logs();
    send(0, 100, 200, 4, 4, a0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sys_rst = 1'b1;
    req1_row = 10'd7; req1_col = 10'd7; req1_nrow = 4'd1; req1_ncol = 4'd1; req1_valid = 1'b1;
    @(negedge clk);
    chk("mr_rdy_in_rst", int'(req1_ready), 0);
    @(posedge clk); #1;
    sys_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mr");
    chk("mr_rdy1_after", int'(req1_ready), 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();
    chk("mr_n_val", val_q.size(), 1);
    if (val_q.size() == 1) begin
      chk("mr_val_tag", val_q[0].a, 1);
      chk("mr_val_cyc", val_q[0].cyc, a0 + 10);
    end
    chk("mr_n_done", done_q.size(), 1);
    if (done_q.size() == 1) chk("mr_done", done_q[0].a, 2);

    // overlap: two 1x1 sweeps, addresses two cycles apart
    clear_logs();
    fork
      send(0, 3, 4, 1, 1, a0);
      send(1, 5, 6, 1, 1, a1);
    join
    wait_idle();
    chk("ov_acc_gap", a1 - a0, 2);
    chk("ov_n_val", val_q.size(), 2);
    if (val_q.size() == 2) begin
      chk("ov_val0_cyc", val_q[0].cyc, a0 + 6);
      chk("ov_val1_cyc", val_q[1].cyc, a0 + 8);
      chk("ov_tags", val_q[0].a * 2 + val_q[1].a, 1);
    end
    chk("ov_n_done", done_q.size(), 2);
    nb = 0;
    foreach (bsy_q[i]) begin
      if (bsy_q[i].cyc >= a0 + 1 && bsy_q[i].cyc <= a0 + 8 && bsy_q[i].a == 1) nb++;
      if (bsy_q[i].cyc == a0 + 9) chk("ov_busy_end", bsy_q[i].a, 0);
    end
    chk("ov_busy_span", nb, 8);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
